// File: rtl/edc_secded_pipe.sv
// edc_secded_pipe: two-stage pipelined SEC-DED decoder/corrector for the
// memory read-return path. Stage S1 computes and registers the syndrome and
// overall parity of the incoming word; stage S2 classifies the error,
// corrects single-bit data errors and registers the result. Both sides use a
// valid/ready handshake with full throughput and no bubbles.
//
// Optional feature: define EDC_ERR_LOG_EN to add a first-error log (address
// tag carried with each word, sticky valid, UE taking precedence over CE).
// The default build (macro undefined) has no log ports or registers.
module edc_secded_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CHK_W-1:0]  i_chk,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err,
  output logic              o_corr,
  output logic              o_ue,
`ifdef EDC_ERR_LOG_EN
  input  logic [31:0]       i_addr,
  output logic              o_log_valid,
  output logic [31:0]       o_log_addr,
  output logic              o_log_ue,
`endif
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_ce_count,
  output logic [CNT_W-1:0]  o_ue_count
);

  // Smallest r with 2^r >= dw + r + 1 (number of Hamming check bits).
  function automatic int calc_r(input int dw);
    int r;
    r = 8;
    for (int k = 8; k >= 1; k--) begin
      if ((1 << k) >= (dw + k + 1)) begin
        r = k;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int R = CHK_W - 1;       // Hamming check bits; chk[R] is overall parity
  localparam int N = DATA_W + R;      // highest valid codeword position

  localparam logic [R-1:0]     N_POS   = R'(N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Codeword position of every data bit, packed R bits per entry. Data bits
  // take the non-power-of-two positions in ascending order (3, 5, 6, 7, 9...).
  function automatic logic [DATA_W*R-1:0] build_pos();
    logic [DATA_W*R-1:0] tbl;
    int                  j;
    tbl = '0;
    j   = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (j < DATA_W) begin
          tbl[j*R +: R] = p[R-1:0];
        end else begin
          tbl = tbl;
        end
        j++;
      end else begin
        j = j;
      end
    end
    return tbl;
  endfunction

  localparam logic [DATA_W*R-1:0] DPOS = build_pos();

  // Parameter legality is checked at elaboration.
  if (DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
    $error("edc_secded_pipe: DATA_W=%0d outside 8..64", DATA_W);
  end
  if (CHK_W != calc_r(DATA_W) + 1) begin : g_bad_chk_w
    $error("edc_secded_pipe: CHK_W=%0d, DATA_W=%0d needs %0d", CHK_W, DATA_W, calc_r(DATA_W) + 1);
  end

  // ---------------------------------------------------------------------
  // Handshake: a stage may load when it is empty or its successor loads.
  // ---------------------------------------------------------------------
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s1_en_s, s2_en_s, xfer_s;

  assign s2_en_s = !s2_v_q || i_ready;
  assign s1_en_s = !s1_v_q || s2_en_s;
  assign o_ready = s1_en_s && !i_reset;
  assign xfer_s  = s1_v_q && s2_en_s;

  // ---------------------------------------------------------------------
  // S1: syndrome and overall parity of the received word
  // ---------------------------------------------------------------------
  logic [R-1:0]      syn_s;
  logic              par_s;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [R-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;

  // Syndrome = XOR of positions of set bits; check bit i lives at 2^i.
  always_comb begin
    syn_s = '0;
    for (int j = 0; j < DATA_W; j++) begin
      if (i_data[j]) begin
        syn_s = syn_s ^ DPOS[j*R +: R];
      end else begin
        syn_s = syn_s;
      end
    end
    for (int i = 0; i < R; i++) begin
      syn_s[i] = syn_s[i] ^ i_chk[i];
    end
    par_s = (^i_data) ^ (^i_chk);
  end

  // S1 next state: load a new word (or bubble) whenever S1 can advance.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_syn_d  = s1_syn_q;
    s1_par_d  = s1_par_q;
    if (s1_en_s) begin
      s1_v_d    = i_valid;
      s1_data_d = i_data;
      s1_syn_d  = syn_s;
      s1_par_d  = par_s;
    end else begin
      s1_v_d    = s1_v_q;
    end
  end

  // S1 registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_syn_q  <= s1_syn_d;
      s1_par_q  <= s1_par_d;
    end
  end

  // ---------------------------------------------------------------------
  // S2: classify, correct and register the output word
  // ---------------------------------------------------------------------
  logic              corr_s, ue_s;
  logic [DATA_W-1:0] cdata_s;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic              s2_corr_q, s2_corr_d;
  logic              s2_ue_q, s2_ue_d;
  logic              s2_err_q, s2_err_d;

  // Odd parity means one error unless the syndrome names no real position;
  // even parity with a non-zero syndrome means two errors.
  always_comb begin
    corr_s  = 1'b0;
    ue_s    = 1'b0;
    cdata_s = s1_data_q;
    if (s1_par_q) begin
      if (s1_syn_q > N_POS) begin
        ue_s = 1'b1;
      end else begin
        corr_s = 1'b1;
      end
    end else begin
      if (s1_syn_q != '0) begin
        ue_s = 1'b1;
      end else begin
        ue_s = 1'b0;
      end
    end
    for (int j = 0; j < DATA_W; j++) begin
      if (corr_s && (s1_syn_q == DPOS[j*R +: R])) begin
        cdata_s[j] = ~s1_data_q[j];
      end else begin
        cdata_s[j] = s1_data_q[j];
      end
    end
  end

  // S2 next state: take S1 contents when the consumer side can advance.
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_corr_d = s2_corr_q;
    s2_ue_d   = s2_ue_q;
    s2_err_d  = s2_err_q;
    if (s2_en_s) begin
      s2_v_d    = s1_v_q;
      s2_data_d = cdata_s;
      s2_corr_d = s1_v_q && corr_s;
      s2_ue_d   = s1_v_q && ue_s;
      s2_err_d  = s1_v_q && (corr_s || ue_s);
    end else begin
      s2_v_d    = s2_v_q;
    end
  end

  // S2 registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_corr_q <= 1'b0;
      s2_ue_q   <= 1'b0;
      s2_err_q  <= 1'b0;
    end else begin
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_corr_q <= s2_corr_d;
      s2_ue_q   <= s2_ue_d;
      s2_err_q  <= s2_err_d;
    end
  end

  assign o_valid = s2_v_q;
  assign o_data  = s2_data_q;
  assign o_corr  = s2_corr_q;
  assign o_ue    = s2_ue_q;
  assign o_err   = s2_err_q;

  // ---------------------------------------------------------------------
  // Saturating error statistics, counted on the S1->S2 transfer
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [CNT_W-1:0] ue_cnt_q, ue_cnt_d;

  // Clear beats a coincident increment; counts stick at all-ones.
  always_comb begin
    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (i_cnt_clr) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else begin
      if (xfer_s && corr_s && (ce_cnt_q != CNT_MAX)) begin
        ce_cnt_d = ce_cnt_q + CNT_ONE;
      end else begin
        ce_cnt_d = ce_cnt_q;
      end
      if (xfer_s && ue_s && (ue_cnt_q != CNT_MAX)) begin
        ue_cnt_d = ue_cnt_q + CNT_ONE;
      end else begin
        ue_cnt_d = ue_cnt_q;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      ue_cnt_q <= ue_cnt_d;
    end
  end

  assign o_ce_count = ce_cnt_q;
  assign o_ue_count = ue_cnt_q;

`ifdef EDC_ERR_LOG_EN
  // ---------------------------------------------------------------------
  // First-error log: address tag rides along in S1 and is captured on the
  // transfer of the first erroneous word; a UE may replace a logged CE.
  // ---------------------------------------------------------------------
  logic [31:0] s1_addr_q, s1_addr_d;
  logic        log_v_q, log_v_d;
  logic [31:0] log_addr_q, log_addr_d;
  logic        log_ue_q, log_ue_d;

  // Address tag follows the S1 data load.
  always_comb begin
    s1_addr_d = s1_addr_q;
    if (s1_en_s) begin
      s1_addr_d = i_addr;
    end else begin
      s1_addr_d = s1_addr_q;
    end
  end

  // Capture rule for the log; clear has priority over capture.
  always_comb begin
    log_v_d    = log_v_q;
    log_addr_d = log_addr_q;
    log_ue_d   = log_ue_q;
    if (i_cnt_clr) begin
      log_v_d    = 1'b0;
      log_addr_d = '0;
      log_ue_d   = 1'b0;
    end else if (xfer_s && (corr_s || ue_s) && (!log_v_q || (!log_ue_q && ue_s))) begin
      log_v_d    = 1'b1;
      log_addr_d = s1_addr_q;
      log_ue_d   = ue_s;
    end else begin
      log_v_d    = log_v_q;
    end
  end

  // Log registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_addr_q  <= '0;
      log_v_q    <= 1'b0;
      log_addr_q <= '0;
      log_ue_q   <= 1'b0;
    end else begin
      s1_addr_q  <= s1_addr_d;
      log_v_q    <= log_v_d;
      log_addr_q <= log_addr_d;
      log_ue_q   <= log_ue_d;
    end
  end

  assign o_log_valid = log_v_q;
  assign o_log_addr  = log_addr_q;
  assign o_log_ue    = log_ue_q;
`endif

endmodule

// File: tb/tb_edc_secded_pipe.sv
// Self-checking bench for edc_secded_pipe (DATA_W=32, CHK_W=7). A second
// instance with CNT_W=4 shares all stimulus to exercise counter saturation.
module tb_edc_secded_pipe;

  logic        clk;
  logic        i_reset, i_valid, i_ready, i_cnt_clr;
  logic [31:0] i_data;
  logic [6:0]  i_chk;
  logic        o_ready, o_valid, o_err, o_corr, o_ue;
  logic [31:0] o_data;
  logic [15:0] o_ce_count, o_ue_count;
  logic        o4_ready, o4_valid, o4_err, o4_corr, o4_ue;
  logic [31:0] o4_data;
  logic [3:0]  o4_ce_count, o4_ue_count;

  edc_secded_pipe #(.DATA_W(32), .CHK_W(7), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_chk(i_chk), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_err(o_err), .o_corr(o_corr), .o_ue(o_ue),
    .i_cnt_clr(i_cnt_clr), .o_ce_count(o_ce_count), .o_ue_count(o_ue_count)
  );

  edc_secded_pipe #(.DATA_W(32), .CHK_W(7), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o4_ready),
    .i_data(i_data), .i_chk(i_chk), .o_valid(o4_valid), .i_ready(i_ready),
    .o_data(o4_data), .o_err(o4_err), .o_corr(o4_corr), .o_ue(o4_ue),
    .i_cnt_clr(i_cnt_clr), .o_ce_count(o4_ce_count), .o_ue_count(o4_ue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        corr;
    logic        ue;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] dflip;
    logic [6:0]  cflip;
    logic [31:0] exp_data;
    logic        exp_corr;
    logic        exp_ue;
  } vec_t;

  exp_t sbq[$];
  exp_t drv_exp;
  int   checks   = 0;
  int   failures = 0;

  logic       pat_en  = 1'b0;
  int         pat_idx = 0;
  logic [3:0] pat     = 4'b1001;   // i_ready sequence 1,0,0,1

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Hamming encoder: check bits make the XOR of set positions zero.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [5:0] s;
    int         pos;
    s   = 6'd0;
    pos = 1;
    for (int j = 0; j < 32; j++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[j]) s = s ^ pos[5:0];
      pos++;
    end
    return {(^d) ^ (^s), s};
  endfunction

  // Scoreboard monitor: compares every valid output against the queue head.
  always @(negedge clk) begin
    if (i_reset) begin
      sbq.delete();
      check("ready_in_reset", 64'(o_ready), 64'(1'b0));
    end else begin
      check("o_ready", 64'(o_ready), 64'((sbq.size() < 2) || i_ready));
      if (o_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual data=%0h expected no o_valid", o_data);
        end else begin
          check("o_data", 64'(o_data), 64'(sbq[0].d));
          check("o_corr", 64'(o_corr), 64'(sbq[0].corr));
          check("o_ue",   64'(o_ue),   64'(sbq[0].ue));
          check("o_err",  64'(o_err),  64'(sbq[0].corr | sbq[0].ue));
          if (i_ready) void'(sbq.pop_front());
        end
      end
      if (i_valid && o_ready) sbq.push_back(drv_exp);
    end
  end

  // Consumer stall pattern for the back-to-back test.
  always @(posedge clk) begin
    if (pat_en) begin
      #1;
      i_ready = pat[pat_idx % 4];
      pat_idx++;
    end
  end

  // Starts just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [6:0] c,
                      input logic [31:0] ed, input logic ec, input logic eu);
    bit acc;
    drv_exp.d    = ed;
    drv_exp.corr = ec;
    drv_exp.ue   = eu;
    i_data  = d;
    i_chk   = c;
    i_valid = 1'b1;
    acc     = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: actual o_ready=0 expected accept within 200 cycles");
    end
  endtask

  // Called right after an accept into an empty pipe with i_ready=1.
  task automatic check_latency(input string name);
    @(negedge clk);
    check({name, "_cyc1"}, 64'(o_valid), 64'(1'b0));
    @(negedge clk);
    check({name, "_cyc2"}, 64'(o_valid), 64'(1'b1));
  endtask

  // Waits (bounded) until every expected word has been consumed.
  task automatic drain();
    for (int k = 0; k < 300 && sbq.size() != 0; k++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: actual pending=%0d expected 0", sbq.size());
    end
    @(negedge clk);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
  endtask

  vec_t        vecs[10];
  int          ce_exp, ue_exp;
  logic [31:0] d;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    i_data = 32'h0; i_chk = 7'h0;
    drv_exp.d = 32'h0; drv_exp.corr = 1'b0; drv_exp.ue = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_o_valid", 64'(o_valid), 64'(1'b0));
    check("rst_o_data",  64'(o_data),  64'(32'h0));
    check("rst_flags",   64'({o_err, o_corr, o_ue}), 64'(3'b000));
    check("rst_ce",      64'(o_ce_count), 64'(16'd0));
    check("rst_ue",      64'(o_ue_count), 64'(16'd0));
    check("rst_ready",   64'(o_ready), 64'(1'b1));
    align();

    // Single error at data bit 0 (position 3), latency 2
    send(32'hDEADBEEF ^ 32'h1, enc(32'hDEADBEEF), 32'hDEADBEEF, 1'b1, 1'b0);
    check_latency("lat_ce");
    drain();
    check("ce_after_sec", 64'(o_ce_count), 64'(16'd1));
    check("ue_after_sec", 64'(o_ue_count), 64'(16'd0));
    align();

    // Double error in data bits 0,1: raw data passes through
    send(32'h12345678 ^ 32'h3, enc(32'h12345678), 32'h1234567B, 1'b0, 1'b1);
    drain();
    check("ce_after_ded", 64'(o_ce_count), 64'(16'd1));
    check("ue_after_ded", 64'(o_ue_count), 64'(16'd1));
    align();
    clear_counts();
    check("ce_cleared", 64'(o_ce_count), 64'(16'd0));

    // Table of single/double/out-of-range patterns
    vecs[0] = '{32'h00000000, 32'h0,        7'h00, 32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h0,        7'h00, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2] = '{32'hA5A5A5A5, 32'h80000000, 7'h00, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[3] = '{32'h0F0F0F0F, 32'h0,        7'h01, 32'h0F0F0F0F, 1'b1, 1'b0};
    vecs[4] = '{32'h00000000, 32'h0,        7'h40, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{32'h12345678, 32'h3,        7'h00, 32'h1234567B, 1'b0, 1'b1};
    vecs[6] = '{32'hCAFEF00D, 32'h00010000, 7'h02, 32'hCAFFF00D, 1'b0, 1'b1};
    vecs[7] = '{32'h55555555, 32'h0,        7'h29, 32'h55555555, 1'b0, 1'b1};
    vecs[8] = '{32'h80000001, 32'h00000040, 7'h00, 32'h80000001, 1'b1, 1'b0};
    vecs[9] = '{32'h00000000, 32'h0,        7'h60, 32'h00000000, 1'b0, 1'b1};
    ce_exp = 0;
    ue_exp = 0;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].data ^ vecs[i].dflip, enc(vecs[i].data) ^ vecs[i].cflip,
           vecs[i].exp_data, vecs[i].exp_corr, vecs[i].exp_ue);
      ce_exp += int'(vecs[i].exp_corr);
      ue_exp += int'(vecs[i].exp_ue);
    end
    drain();
    check("tbl_ce", 64'(o_ce_count), 64'(ce_exp));
    check("tbl_ue", 64'(o_ue_count), 64'(ue_exp));
    align();

    // 8 back-to-back clean words with the consumer stalling 1,0,0,1
    pat_idx = 0;
    pat_en  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = 32'h10000000 + 32'(k) * 32'h01010101;
      send(d, enc(d), d, 1'b0, 1'b0);
    end
    drain();
    pat_en = 1'b0;
    @(posedge clk);
    #2 i_ready = 1'b1;

    // Saturation on the 4-bit instance, then clear against a 21st error
    clear_counts();
    for (int k = 0; k < 20; k++) begin
      d = $urandom;
      send(d ^ (32'h1 << (k % 32)), enc(d), d, 1'b1, 1'b0);
    end
    drain();
    check("sat_ce4",  64'(o4_ce_count), 64'(4'd15));
    check("sat_ce16", 64'(o_ce_count),  64'(16'd20));
    align();
    d = 32'hF00DCAFE;
    send(d ^ 32'h00000100, enc(d), d, 1'b1, 1'b0);
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1 i_cnt_clr = 1'b0;
    drain();
    check("clr_ce4",  64'(o4_ce_count), 64'(4'd0));
    check("clr_ce16", 64'(o_ce_count),  64'(16'd0));
    align();

    // Reset with two words in flight
    send(32'h11112222 ^ 32'h4, enc(32'h11112222), 32'h11112222, 1'b1, 1'b0);
    send(32'h33334444 ^ 32'h3, enc(32'h33334444), 32'h33334444 ^ 32'h3, 1'b0, 1'b1);
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_no_valid", 64'(o_valid), 64'(1'b0));
    end
    check("flush_ce", 64'(o_ce_count), 64'(16'd0));
    check("flush_ue", 64'(o_ue_count), 64'(16'd0));
    align();
    send(32'h0BADF00D, enc(32'h0BADF00D), 32'h0BADF00D, 1'b0, 1'b0);
    check_latency("lat_post_rst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edc_secded_pipe.md
Name: edc_secded_pipe

Overview:
Parametrised, pipelined SEC-DED decoder/corrector; the next generation of the memory-read EDC path.
- Takes a raw data word plus stored check bits and computes the syndrome internally.
- Corrects any single-bit error and flags double-bit errors.
- Keeps saturating error statistics.
- Sits between the main-memory read data return and the consumer, with a valid/ready handshake on both sides.

Parameters:
DATA_W, 32, data word width; legal range 8..64.
CHK_W, 7, check-bit count; must equal r+1, where r is the smallest integer with 2^r >= DATA_W+r+1. A mismatch is an elaboration error.
CNT_W, 16, width of each saturating error counter.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_valid  in  1  input word valid.
o_ready  out  1  block can accept an input word this cycle.
i_data  in  DATA_W  received data, bit 0 = LSB.
i_chk  in  CHK_W  received check bits; bits 0..r-1 Hamming, bit r overall parity.
o_valid  out  1  output word valid.
i_ready  in  1  consumer accepts the output word.
o_data  out  DATA_W  corrected data.
o_err  out  1  any error detected in this word.
o_corr  out  1  single error corrected in this word.
o_ue  out  1  uncorrectable (double) error in this word.
i_cnt_clr  in  1  clear both counters.
o_ce_count  out  CNT_W  corrected-error count.
o_ue_count  out  CNT_W  uncorrectable-error count.

Behaviour:
Code definition:
- Codeword positions are 1..DATA_W+r.
- Hamming check bit i sits at position 2^i.
- Data bits fill the remaining positions in ascending order: data bit 0 at position 3, bit 1 at 5, bit 2 at 6, bit 3 at 7, bit 4 at 9, and so on.
- Overall parity chk[r] is the XOR of all data bits and chk[0..r-1] (even parity).

Decode:
- syn = XOR of the position indices of all set codeword bits.
- p = XOR of all data and check bits.
- Classification:
  - syn=0, p=0: no error.
  - p=1: single error at position syn; syn=0 means chk[r] itself is in error. Flip the data bit at that position if it holds data. Set o_corr=1, o_err=1.
  - syn!=0, p=0: uncorrectable. o_data = i_data unmodified; o_ue=1, o_err=1.
  - p=1 with syn > DATA_W+r (no such position): treat as uncorrectable, same as above.
- o_ue and o_corr are never both 1.

Pipeline:
- Stage S1 registers data, syn and p.
- Stage S2 registers o_data and the flags.
- Latency is exactly 2 cycles from input accept to o_valid when there is no stall.
- Full throughput: 1 word per cycle.

Handshake:
- Input accepted when i_valid & o_ready. Output consumed when o_valid & i_ready.
- s2_en = !s2_v | i_ready.
- s1_en = !s1_v | s2_en.
- o_ready = s1_en; a combinational path from i_ready to o_ready is permitted.
- While o_valid=1 and i_ready=0, o_data and all flags hold stable.
- No bubbles are inserted and no word is dropped or duplicated.

Counters:
- On each S1->S2 transfer, o_ce_count increments if the word is corrected and o_ue_count increments if it is uncorrectable.
- Both saturate at 2^CNT_W-1.
- i_cnt_clr has priority: if it coincides with an increment, the count becomes 0 and that event is not counted.

Reset:
- s1_v, s2_v, o_valid, o_err, o_corr, o_ue, o_data and both counters are all 0.
- o_ready=1 in the cycle after reset deasserts.
- Reset mid-stream discards in-flight words; they are not counted.
- While i_reset=1, o_ready=0.

Optional Feature:
EDC_ERR_LOG_EN
- Enabled, adds ports:
  - i_addr [31:0]: tag carried with the word through S1/S2.
  - o_log_valid: sticky.
  - o_log_addr [31:0].
  - o_log_ue.
- Logging: on the first S1->S2 transfer with an error, latch addr and ue and set o_log_valid. Later errors leave the log unchanged.
- Exception: if the log holds a corrected error and an uncorrectable one arrives, overwrite it (UE has precedence).
- i_cnt_clr also clears the log; clear wins over capture in the same cycle.
- Disabled: none of these ports or registers exist.

Test Plan:
- Encode 0xDEADBEEF, flip data bit 0 (position 3) -> o_data=0xDEADBEEF, o_corr=1, o_ue=0, o_valid exactly 2 cycles after accept, o_ce_count=1.
- Flip data bits 0 and 1 of 0x12345678 -> o_data=0x12345678 with bits 0,1 flipped (i.e. the raw input, 0x1234567B), o_ue=1, o_corr=0, o_ue_count=1.
- Flip only chk[6] of 0x00000000 (DATA_W=32) -> o_data=0, o_corr=1, o_err=1.
- 8 back-to-back clean words with i_ready toggling 1,0,0,1 -> all 8 words out in order, stable while stalled, o_ready low only when both stages are full and i_ready=0.
- CNT_W=4, 20 single-error words, then i_cnt_clr coinciding with a 21st error -> o_ce_count reads 15, then 0.
- Assert i_reset with 2 words in flight -> no o_valid afterwards, counters 0, next word has 2-cycle latency.
